// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result queues feeding a single common data bus broadcast.
// Latency: a result accepted at edge k is broadcast (cdb_valid high) after edge k+1 at the earliest.
// Backpressure: fu_ready[i] drops while queue i holds QDEPTH entries; the source holds its result.
//
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   fu_valid/fu_ready   - per-source handshake (0-2 ALUs, 3 load/store)
//   fu_tag/value/rob    - packed per-source payloads, source i at [i*W +: W]
//   cdb_valid/tag/value/rob - registered broadcast toward rename and ROB wakeup
// Build option: define CDB_RR_EN for round-robin arbitration; otherwise fixed
// priority with source 0 highest.
module cdb_arbiter #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 6,
    parameter int QDEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            fu_valid,
    output logic [3:0]            fu_ready,
    input  logic [4*TAG_W-1:0]    fu_tag,
    input  logic [4*DATA_W-1:0]   fu_value,
    input  logic [4*ROB_W-1:0]    fu_rob,
    output logic                  cdb_valid,
    output logic [TAG_W-1:0]      cdb_tag,
    output logic [DATA_W-1:0]     cdb_value,
    output logic [ROB_W-1:0]      cdb_rob
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic [ROB_W-1:0]  rob;
    } entry_t;

    entry_t             mem    [4][QDEPTH];
    entry_t             din    [4];
    logic [PTR_W-1:0]   wr_ptr [4];
    logic [PTR_W-1:0]   rd_ptr [4];
    logic [CNT_W-1:0]   count  [4];

    logic [3:0]         push;
    logic [3:0]         pop;
    logic [3:0]         not_empty;
    logic               grant_vld;
    logic [1:0]         grant_idx;
    entry_t             head;

    // Ready depends only on the registered count so it never combinationally
    // follows the arbiter's decision in the same cycle.
    always_comb begin
        fu_ready  = '0;
        not_empty = '0;
        for (int i = 0; i < 4; i++) begin
            fu_ready[i]  = (count[i] < CNT_W'(QDEPTH));
            not_empty[i] = (count[i] != '0);
            din[i]       = '{tag:   fu_tag[i*TAG_W +: TAG_W],
                             value: fu_value[i*DATA_W +: DATA_W],
                             rob:   fu_rob[i*ROB_W +: ROB_W]};
        end
    end

    assign push = fu_valid & fu_ready;

`ifdef CDB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;

    // Scan offsets from farthest to nearest so the source closest to rr_ptr
    // (upward, modulo 4) is the last assignment and therefore wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (not_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`else
    // Fixed priority: lowest-numbered non-empty source wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (not_empty[k]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(k);
            end
        end
    end
`endif

    always_comb begin
        pop = '0;
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
        head = mem[grant_idx][rd_ptr[grant_idx]];
    end

    // Payload storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= din[i];
            end
        end
    end

    // QDEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Broadcast register; payload holds its last value on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_rob   <= '0;
        end else if (grant_vld) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head.tag;
            cdb_value <= head.value;
            cdb_rob   <= head.rob;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   fu_valid;
    logic [3:0]   fu_ready;
    logic [23:0]  fu_tag;
    logic [127:0] fu_value;
    logic [23:0]  fu_rob;
    logic         cdb_valid;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_value;
    logic [5:0]   cdb_rob;

    cdb_arbiter #(.TAG_W(6), .DATA_W(32), .ROB_W(6), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_value(fu_value), .fu_rob(fu_rob),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_rob(cdb_rob)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
        logic [5:0]  rob;
    } res_t;

    // Per-source scoreboard: accepted results in push order.
    res_t sb [4][$];
    int   seq [4];
    int   passed = 0;
    int   total  = 0;

    task automatic set_src(input int s, input logic [5:0] t, input logic [31:0] v, input logic [5:0] r);
        fu_tag[s*6 +: 6]    = t;
        fu_value[s*32 +: 32] = v;
        fu_rob[s*6 +: 6]    = r;
    endtask

    task automatic load_next(input int s);
        logic [15:0] rnd;
        rnd = 16'($urandom);
        set_src(s, {s[1:0], seq[s][3:0]}, {s[7:0], seq[s][7:0], rnd}, 6'(seq[s] * 4 + s));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        fu_valid = '0;
        for (int s = 0; s < 4; s++) begin
            sb[s].delete();
            seq[s] = 0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance one cycle. Records accepted pushes into the scoreboard, then
    // identifies which source's queue head the broadcast matches (-1: none).
    task automatic tick(output logic [3:0] acc, output logic v, output int src);
        res_t e;
        acc = fu_valid & fu_ready;
        for (int s = 0; s < 4; s++) begin
            if (acc[s]) begin
                e = {fu_tag[s*6 +: 6], fu_value[s*32 +: 32], fu_rob[s*6 +: 6]};
                sb[s].push_back(e);
            end
        end
        @(negedge clk);
        v   = cdb_valid;
        src = -1;
        if (cdb_valid === 1'b1) begin
            e = {cdb_tag, cdb_value, cdb_rob};
            for (int s = 0; s < 4; s++) begin
                if (src < 0 && sb[s].size() > 0 && sb[s][0] === e) begin
                    src = s;
                    void'(sb[s].pop_front());
                end
            end
        end
    endtask

    task automatic advance(input logic [3:0] acc);
        for (int s = 0; s < 4; s++) begin
            if (acc[s]) begin
                seq[s]++;
                load_next(s);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] acc;
        logic       v;
        int         src;
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        fu_rob   = '0;
        reset    = 1'b1;
        #1;
        total++; if (fu_ready !== 4'hF) $display("FAIL reset_ready: got %b expected 1111", fu_ready); else passed++;
        total++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cdb_valid); else passed++;
        total++; if (cdb_tag !== 6'd0) $display("FAIL reset_tag: got %0h expected 0", cdb_tag); else passed++;
        total++; if (cdb_value !== 32'd0) $display("FAIL reset_value: got %0h expected 0", cdb_value); else passed++;
        total++; if (cdb_rob !== 6'd0) $display("FAIL reset_rob: got %0h expected 0", cdb_rob); else passed++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(acc, v, src);
        total++; if (fu_ready !== 4'hF) $display("FAIL post_reset_ready: got %b expected 1111", fu_ready); else passed++;
        total++; if (v !== 1'b0) $display("FAIL post_reset_valid: got %b expected 0", v); else passed++;
    endtask

    task automatic test_single();
        logic [3:0] acc;
        logic       v;
        int         src;
        apply_reset();
        set_src(1, 6'd5, 32'hDEADBEEF, 6'd3);
        fu_valid = 4'b0010;
        tick(acc, v, src);
        fu_valid = '0;
        total++; if (acc !== 4'b0010) $display("FAIL single_accept: got %b expected 0010", acc); else passed++;
        total++; if (v !== 1'b0) $display("FAIL single_early: cdb_valid %b expected 0", v); else passed++;
        tick(acc, v, src);
        total++; if (v !== 1'b1) $display("FAIL single_valid: got %b expected 1", v); else passed++;
        total++; if (src !== 1) $display("FAIL single_src: matched source %0d expected 1", src); else passed++;
        total++; if ({cdb_tag, cdb_value, cdb_rob} !== {6'd5, 32'hDEADBEEF, 6'd3})
            $display("FAIL single_payload: got %0h/%0h/%0h expected 5/deadbeef/3", cdb_tag, cdb_value, cdb_rob); else passed++;
        tick(acc, v, src);
        total++; if (v !== 1'b0) $display("FAIL single_idle: got %b expected 0", v); else passed++;
        total++; if (cdb_tag !== 6'd5) $display("FAIL single_hold: tag %0h expected 5", cdb_tag); else passed++;
    endtask

    task automatic test_simultaneous();
        logic [3:0] acc;
        logic       v;
        int         src;
        apply_reset();
        for (int s = 0; s < 4; s++) load_next(s);
        fu_valid = 4'hF;
        tick(acc, v, src);
        fu_valid = '0;
        total++; if (v !== 1'b0) $display("FAIL simul_first: got %b expected 0", v); else passed++;
        for (int k = 0; k < 4; k++) begin
            tick(acc, v, src);
            total++; if (src !== k) $display("FAIL simul_order%0d: matched source %0d expected %0d", k, src, k); else passed++;
        end
        tick(acc, v, src);
        total++; if (v !== 1'b0) $display("FAIL simul_end: got %b expected 0", v); else passed++;
    endtask

    task automatic test_full();
        logic [3:0] acc;
        logic       v;
        int         src;
        int         n2 = 0;
        int         unmatched = 0;
        apply_reset();
        for (int s = 0; s < 4; s++) load_next(s);
        for (int cyc = 0; cyc < 40; cyc++) begin
            fu_valid = {1'b0, seq[2] < 3, cyc < 6, cyc < 6};
            tick(acc, v, src);
            if (v === 1'b1 && src < 0) unmatched++;
            if (src == 2) n2++;
            advance(acc);
            if (acc[2] && seq[2] == 2) begin
                total++; if (fu_ready[2] !== 1'b0) $display("FAIL full_ready2: got %b expected 0", fu_ready[2]); else passed++;
            end
        end
        fu_valid = '0;
        total++; if (seq[2] !== 3) $display("FAIL full_accepted: got %0d expected 3", seq[2]); else passed++;
        total++; if (n2 !== 3) $display("FAIL full_bcast2: got %0d expected 3", n2); else passed++;
        total++; if (unmatched !== 0) $display("FAIL full_unmatched: got %0d expected 0", unmatched); else passed++;
        total++; if (sb[0].size() + sb[1].size() + sb[2].size() !== 0)
            $display("FAIL full_leftover: got %0d expected 0", sb[0].size() + sb[1].size() + sb[2].size()); else passed++;
    endtask

    task automatic test_fairness();
        logic [3:0] acc;
        logic       v;
        int         src;
        int         grants[$];
        int         exp;
        apply_reset();
        load_next(0);
        load_next(3);
        for (int cyc = 0; cyc < 20; cyc++) begin
            fu_valid = (cyc < 12) ? 4'b1001 : 4'b0000;
            tick(acc, v, src);
            if (v === 1'b1) grants.push_back(src);
            advance(acc);
        end
        fu_valid = '0;
        total++; if (grants.size() < 8) $display("FAIL fair_count: got %0d expected at least 8", grants.size()); else passed++;
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
`ifdef CDB_RR_EN
            exp = (k % 2 == 0) ? 0 : 3;
`else
            exp = 0;
`endif
            total++; if (grants[k] !== exp) $display("FAIL fair_grant%0d: got %0d expected %0d", k, grants[k], exp); else passed++;
        end
        total++; if (sb[0].size() + sb[3].size() !== 0)
            $display("FAIL fair_leftover: got %0d expected 0", sb[0].size() + sb[3].size()); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [3:0] acc;
        logic       v;
        int         src;
        int         nvalid = 0;
        apply_reset();
        for (int s = 0; s < 4; s++) load_next(s);
        fu_valid = 4'hF;
        tick(acc, v, src);
        advance(acc);
        fu_valid = 4'b1100;
        tick(acc, v, src);
        advance(acc);
        fu_valid = '0;
        total++; if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() !== 5)
            $display("FAIL midrst_depth: got %0d expected 5", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()); else passed++;
        total++; if (v !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", v); else passed++;
        reset = 1'b1;
        #1;
        total++; if (cdb_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", cdb_valid); else passed++;
        total++; if (fu_ready !== 4'hF) $display("FAIL midrst_ready: got %b expected 1111", fu_ready); else passed++;
        for (int s = 0; s < 4; s++) sb[s].delete();
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick(acc, v, src);
            if (v === 1'b1) nvalid++;
        end
        total++; if (nvalid !== 0) $display("FAIL midrst_stale: got %0d broadcasts expected 0", nvalid); else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] acc;
        logic       v;
        int         src;
        int         n3 = 0;
        apply_reset();
        load_next(3);
        for (int cyc = 0; cyc < 16; cyc++) begin
            fu_valid = {seq[3] < 10, 3'b000};
            tick(acc, v, src);
            if (v === 1'b1) begin
                n3++;
                total++; if (src !== 3) $display("FAIL wrap_match%0d: matched source %0d expected 3", n3, src); else passed++;
            end
            advance(acc);
        end
        fu_valid = '0;
        total++; if (n3 !== 10) $display("FAIL wrap_count: got %0d expected 10", n3); else passed++;
        total++; if (sb[3].size() !== 0) $display("FAIL wrap_leftover: got %0d expected 0", sb[3].size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_full();
        test_fairness();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter TAG_W, 6: physical register tag width.
REQ-002 Parameter DATA_W, 32: result value width.
REQ-003 Parameter ROB_W, 6: ROB index width.
REQ-004 Parameter QDEPTH, 2: per-source result queue depth, power of two, >=2.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 fu_valid  input  4  per-source result valid; sources 0-2 are ALUs 0-2, source 3 is load/store.
REQ-008 fu_ready  output  4  per-source queue can accept a result.
REQ-009 fu_tag  input  4*TAG_W  packed destination physical tags; source i occupies bits [i*TAG_W +: TAG_W].
REQ-010 fu_value  input  4*DATA_W  packed result values, same packing rule.
REQ-011 fu_rob  input  4*ROB_W  packed ROB indices, same packing rule.
REQ-012 cdb_valid  output  1  broadcast active this cycle; drives rename and ROB wakeup_active.
REQ-013 cdb_tag  output  TAG_W  broadcast tag; drives rename wakeup_tag.
REQ-014 cdb_value  output  DATA_W  broadcast value; drives rename wakeup_value.
REQ-015 cdb_rob  output  ROB_W  broadcast ROB index; drives ROB wakeup_rob_index.

Function
REQ-016 Four independent FIFOs of QDEPTH entries; each entry holds {tag, value, rob}.
REQ-017 fu_ready[i] = queue i count < QDEPTH; computed from registered count only, never from the same-cycle pop.
REQ-018 Push into queue i on a rising edge where fu_valid[i] and fu_ready[i] are both high; fu_valid[i] with fu_ready[i] low is ignored, and the source holds the result.
REQ-019 Each cycle the arbiter combinationally selects at most one non-empty queue head; the selected head pops on the next edge.
REQ-020 The popped entry registers onto cdb_tag/cdb_value/cdb_rob with cdb_valid=1 on that same edge.
REQ-021 Cycles with no non-empty queue: cdb_valid=0 at the next edge; cdb_tag/value/rob hold their previous values.
REQ-022 Minimum latency: result pushed at edge k is broadcast with cdb_valid high after edge k+1.
REQ-023 Order within one source is FIFO; no ordering guarantee across sources.
REQ-024 Simultaneous push and pop on the same queue in one edge is legal; count is unchanged and the pointers each advance.
REQ-025 Push and pop pointers wrap modulo QDEPTH.
REQ-026 Exactly one broadcast per granted cycle; no entry is duplicated or dropped.

Reset
REQ-027 Asserting reset at any time empties all queues, zeroes the pointers and counts, sets rr_ptr=0, cdb_valid=0, and cdb_tag/value/rob=0.
REQ-028 During and immediately after reset fu_ready=4'b1111.
REQ-029 Results queued when reset is asserted mid-operation are discarded and never broadcast.

Configuration
REQ-030 With macro CDB_RR_EN defined: round-robin arbitration using a 2-bit rr_ptr.
REQ-031 Round-robin search runs upward from rr_ptr modulo 4; after granting source g, rr_ptr <= g+1 mod 4; rr_ptr is unchanged when there is no grant.
REQ-032 With CDB_RR_EN defined, a non-empty queue is granted within 4 cycles.
REQ-033 Without CDB_RR_EN: fixed priority, source 0 highest and source 3 lowest; no rr_ptr state exists.

Verification
REQ-034 Single push: source 1 with tag=5, value=0xDEADBEEF, rob=3 at edge 1 -> cdb_valid=1 with tag=5, value=0xDEADBEEF, rob=3 after edge 2, and cdb_valid=0 after edge 3.
REQ-035 Full queue: source 2 pushes 3 results with no grant possible while the arbiter is held busy by sources 0 and 1 -> fu_ready[2]=0 after 2 pushes; the third result is held by the source and accepted later, with all 3 broadcast in push order.
REQ-036 Simultaneous events: all 4 sources push at the same edge, CDB_RR_EN defined, rr_ptr=0 -> broadcasts follow source order 0,1,2,3 on 4 consecutive cycles; without the macro the order is also 0,1,2,3.
REQ-037 Fairness: sources 0 and 3 push continuously -> with CDB_RR_EN the grants alternate 0,3,0,3; without it source 3 is starved while source 0 keeps its queue full.
REQ-038 Reset mid-operation: assert reset with 5 entries queued -> cdb_valid=0 immediately, fu_ready=4'b1111, and no stale entry is broadcast after reset is released.
REQ-039 Wrap-around: stream 10 results through source 3 one per cycle -> 10 broadcasts with matching tags and rob indices, none lost across pointer wrap.
